// File: rtl/uart_rx_frame_controller.sv
// UART receive frame sequencer: start detect, mid-bit sampling on a 16x tick, framing/parity check.
// Latency: packet_completion and status registers update 1 clk after the stop-bit sample tick.
// Backpressure: none; Rx_EN low aborts the frame in progress. Optional build macro: RX_MAJORITY_VOTE_EN.
module uart_rx_frame_controller #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Rx_EN,
  input  logic        baud_tick,
  input  logic        RxD,
  output logic [10:0] packet,
  output logic        packet_completion,
  output logic [7:0]  Rx_DATA,
  output logic        Rx_VALID,
  output logic        Rx_PERROR,
  output logic        Rx_FERROR,
  output logic        busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic          bit_val;
  logic          parity_err;

`ifdef RX_MAJORITY_VOTE_EN
  // The two ticks preceding the decision tick, voted together with the live line value
  logic [1:0] rx_hist;

  // Track the line on every tick so the vote window is always filled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_hist <= 2'b11;
    end else if (baud_tick) begin
      rx_hist <= {rx_hist[0], RxD};
    end
  end

  assign bit_val = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & RxD) | (rx_hist[0] & RxD);
`else
  assign bit_val = RxD;
`endif

  // Data and parity bits are all in place by the time the stop bit is sampled
  assign parity_err = (^packet[9:1]) != PARITY_ODD;

  // Frame sequencer: state, counters, packet capture and registered status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      tick_cnt          <= '0;
      bit_idx           <= '0;
      packet            <= '0;
      packet_completion <= 1'b0;
      Rx_DATA           <= '0;
      Rx_VALID          <= 1'b0;
      Rx_PERROR         <= 1'b0;
      Rx_FERROR         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      packet_completion <= 1'b0;
      if (state != S_IDLE && !Rx_EN) begin
        // Disable overrides any tick in the same clk; status from the last frame is kept
        state    <= S_IDLE;
        tick_cnt <= '0;
        bit_idx  <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (Rx_EN && baud_tick && !RxD) begin
              state     <= S_START;
              tick_cnt  <= '0;
              bit_idx   <= '0;
              busy      <= 1'b1;
              Rx_VALID  <= 1'b0;
              Rx_PERROR <= 1'b0;
              Rx_FERROR <= 1'b0;
            end
          end
          S_START: begin
            if (baud_tick) begin
              if (tick_cnt == HALF_LAST) begin
                tick_cnt <= '0;
                if (bit_val) begin
                  // Line returned high before mid-bit: treat as noise
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end else begin
                  packet[0] <= 1'b0;
                  state     <= S_DATA;
                end
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end
          S_DATA: begin
            if (baud_tick) begin
              if (tick_cnt == FULL_LAST) begin
                tick_cnt                      <= '0;
                packet[4'(bit_idx) + 4'd1]    <= bit_val;
                if (bit_idx == 3'd7) begin
                  bit_idx <= '0;
                  state   <= S_PARITY;
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end
          S_PARITY: begin
            if (baud_tick) begin
              if (tick_cnt == FULL_LAST) begin
                tick_cnt  <= '0;
                packet[9] <= bit_val;
                state     <= S_STOP;
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end
          S_STOP: begin
            if (baud_tick) begin
              if (tick_cnt == FULL_LAST) begin
                // Status is published together with the stop sample so completion lands one clk later
                tick_cnt          <= '0;
                packet[10]        <= bit_val;
                packet_completion <= 1'b1;
                Rx_DATA           <= packet[8:1];
                Rx_PERROR         <= parity_err;
                Rx_FERROR         <= ~bit_val;
                Rx_VALID          <= ~(parity_err | ~bit_val);
                state             <= S_DONE;
              end else begin
                tick_cnt <= tick_cnt + CW'(1);
              end
            end
          end
          S_DONE: begin
            // Single clk, not tick gated, so the very next tick may start a new frame
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Bench for uart_rx_frame_controller: directed UART frames with a frame-level expectation model.
// Each tick lasts 2 clks; outputs are compared 1 time unit after every rising edge.
// The driver paces itself, so the run always ends after a fixed number of ticks.
module tb_uart_rx_frame_controller;

  localparam int OS   = 16;
  localparam bit PODD = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Rx_EN = 1'b0;
  logic        baud_tick = 1'b0;
  logic        RxD = 1'b1;
  logic [10:0] packet;
  logic        packet_completion;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID, Rx_PERROR, Rx_FERROR, busy;

  // Driver annotations: first tick of a frame, and the stop-bit centre tick of a frame expected to complete
  logic start_mark = 1'b0;
  logic stop_mark  = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct packed {
    logic [10:0] pkt;
    logic        perr;
    logic        ferr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_perr  = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_comp;

  always #5 clk = ~clk;

  uart_rx_frame_controller #(.OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .baud_tick(baud_tick), .RxD(RxD),
    .packet(packet), .packet_completion(packet_completion), .Rx_DATA(Rx_DATA),
    .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // What a frame must produce, straight from the frame format and parity rule
  function automatic exp_t model(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.pkt  = {s, p, d, 1'b0};
    e.perr = ((^d) ^ p) != PODD;
    e.ferr = ~s;
    return e;
  endfunction

  // Compare process: every cycle, after the edge has settled
  always @(posedge clk) begin
    #1;
    if (packet_completion) pulses++;
    if (!reset) begin
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_perr  = 1'b0;
      exp_ferr  = 1'b0;
      chk("rst_packet", packet, 0);
      chk("rst_completion", packet_completion, 0);
    end else begin
      if (baud_tick && start_mark && Rx_EN) begin
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
      end
      exp_comp = baud_tick && stop_mark && Rx_EN;
      chk("completion", packet_completion, exp_comp);
      if (exp_comp) begin
        if (exp_q.size() == 0) begin
          chk("model_queue", 1, 0);
        end else begin
          cur       = exp_q.pop_front();
          exp_data  = cur.pkt[8:1];
          exp_perr  = cur.perr;
          exp_ferr  = cur.ferr;
          exp_valid = ~(cur.perr | cur.ferr);
          chk("packet", packet, cur.pkt);
        end
      end
    end
    chk("Rx_DATA", Rx_DATA, exp_data);
    chk("Rx_VALID", Rx_VALID, exp_valid);
    chk("Rx_PERROR", Rx_PERROR, exp_perr);
    chk("Rx_FERROR", Rx_FERROR, exp_ferr);
  end

  task automatic tick(input logic v, input logic st, input logic sp, input logic en);
    @(negedge clk);
    RxD = v; baud_tick = 1'b1; start_mark = st; stop_mark = sp; Rx_EN = en;
    @(negedge clk);
    baud_tick = 1'b0; start_mark = 1'b0; stop_mark = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // cut_tick < 0: full frame. Otherwise at that tick either reset is pulsed or Rx_EN drops with the tick.
  task automatic send(input logic [7:0] d, input logic p, input logic s,
                      input int cut_tick, input bit cut_rst, input bit glitch);
    logic [10:0] b;
    logic        v;
    logic        en;
    bit          full;
    b    = {s, p, d, 1'b0};
    en   = 1'b1;
    full = (cut_tick < 0);
    if (full) exp_q.push_back(model(d, p, s));
    for (int g = 0; g < 11*OS; g++) begin
      v = b[g/OS];
      if (g/OS == 10 && g%OS > OS/2) v = 1'b1;
      if (glitch && g%OS == OS/2) v = ~v;
      if (g == cut_tick) begin
        if (cut_rst) begin
          chk("busy_mid_frame", busy, 1);
          @(negedge clk);
          reset = 1'b0;
          #1;
          chk("rst_now_packet", packet, 0);
          chk("rst_now_data", Rx_DATA, 0);
          chk("rst_now_valid", Rx_VALID, 0);
          chk("rst_now_busy", busy, 0);
          chk("rst_now_flags", {Rx_PERROR, Rx_FERROR, packet_completion}, 0);
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        en = 1'b0;
      end
      tick(v, g == 0, full && g == 10*OS + OS/2, en);
      if (g == cut_tick) chk("busy_after_disable", busy, 0);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_packet", packet, 0);
    chk("reset_valid", Rx_VALID, 0);
    reset = 1'b1;
    Rx_EN = 1'b1;
    idle_ticks(4);

    // Clean even-parity frame
    send(8'hA5, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    idle_ticks(2);
    chk("a5_packet", packet, 11'b1_0_10100101_0);
    chk("a5_data", Rx_DATA, 8'hA5);
    chk("a5_valid", Rx_VALID, 1);
    chk("a5_pulses", pulses, 1);
    chk("a5_busy", busy, 0);

    // Reset during data bit 3
    send(8'hA5, 1'b0, 1'b1, 4*OS + 3, 1'b1, 1'b0);
    idle_ticks(20);
    chk("rst_pulses", pulses, 1);

    // Parity error
    send(8'h3C, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    idle_ticks(2);
    chk("3c_perr", Rx_PERROR, 1);
    chk("3c_valid", Rx_VALID, 0);
    chk("3c_data", Rx_DATA, 8'h3C);
    chk("3c_pulses", pulses, 2);

    // Framing error
    send(8'h81, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    idle_ticks(2);
    chk("81_ferr", Rx_FERROR, 1);
    chk("81_valid", Rx_VALID, 0);
    chk("81_pulses", pulses, 3);

    // Short low glitch: false start, no frame
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(20);
    chk("glitch_busy", busy, 0);
    chk("glitch_pulses", pulses, 3);

    // Rx_EN drops on the parity sample tick
    send(8'h11, 1'b0, 1'b1, 9*OS + OS/2, 1'b0, 1'b0);
    idle_ticks(4);
    chk("disable_pulses", pulses, 3);

    // Back-to-back frames
    send(8'h11, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    send(8'hEE, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    idle_ticks(2);
    chk("b2b_pulses", pulses, 5);
    chk("b2b_data", Rx_DATA, 8'hEE);
    chk("b2b_valid", Rx_VALID, 1);

`ifdef RX_MAJORITY_VOTE_EN
    // Centre-sample glitch on every bit is outvoted
    send(8'h5A, 1'b0, 1'b1, -1, 1'b0, 1'b1);
    idle_ticks(2);
    chk("vote_data", Rx_DATA, 8'h5A);
    chk("vote_valid", Rx_VALID, 1);
    chk("vote_pulses", pulses, 6);
`endif

    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
